// File: rtl/jump_branch_ctrl_if.sv
// ---------------------------------------------------------------------------
// jump_branch_ctrl_if
// Op channel into the jump/branch control unit: a valid/ready handshake that
// carries the opcode, the op's PC and offset, and the ALU flag write port
// (the flag port travels with the op so same-cycle forwarding lines up).
//
//   op_valid  producer -> unit   op present
//   op_ready  unit -> producer   unit can accept an op (IDLE only)
//   op_code   producer -> unit   4-bit opcode
//   pc        producer -> unit   address of the op
//   offset    producer -> unit   branch offset / jump address
//   flag_we   producer -> unit   load ALU flags this cycle
//   alu_zero  producer -> unit   zero flag from ALU
//   alu_sign  producer -> unit   sign flag from ALU
// ---------------------------------------------------------------------------
interface jump_branch_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 8
) ();
  logic              op_valid;
  logic              op_ready;
  logic [3:0]        op_code;
  logic [ADDR_W-1:0] pc;
  logic [OFF_W-1:0]  offset;
  logic              flag_we;
  logic              alu_zero;
  logic              alu_sign;

  // Producer side (decode stage / testbench).
  modport master (
    output op_valid, op_code, pc, offset, flag_we, alu_zero, alu_sign,
    input  op_ready
  );

  // Unit side.
  modport slave (
    input  op_valid, op_code, pc, offset, flag_we, alu_zero, alu_sign,
    output op_ready
  );
endinterface

// File: rtl/jump_branch_ctrl.sv
// ---------------------------------------------------------------------------
// jump_branch_ctrl
// Sequential jump/branch resolution unit. Keeps a Z/S condition-flag
// register, accepts control ops over a valid/ready handshake and resolves
// each one a cycle after acceptance. A taken op raises a one-cycle redirect
// (plus link write for JAL) and then holds flush for FLUSH_DEPTH cycles.
// Saturating counters track accepted control ops and taken ops.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   op                op channel (slave side of jump_branch_ctrl_if)
//   jump_branch_flag  registered taken result of the last control op
//   target_pc         registered next PC of the last control op
//   redirect          one-cycle pulse in RESOLVE when taken
//   flush             high for FLUSH_DEPTH cycles after a taken op
//   link_we           one-cycle pulse in RESOLVE for a JAL
//   link_data         PC+1 of the last JAL
//   cnt_clr           synchronous clear of both counters (beats increments)
//   br_cnt            accepted control ops, saturating
//   taken_cnt         taken control ops, saturating
//
// OFF_W must not exceed ADDR_W; op must be built with the same ADDR_W/OFF_W.
// ---------------------------------------------------------------------------
module jump_branch_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int OFF_W       = 8,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  jump_branch_ctrl_if.slave op,
  output logic              jump_branch_flag,
  output logic [ADDR_W-1:0] target_pc,
  output logic              redirect,
  output logic              flush,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  localparam logic [3:0] OP_BEQ = 4'b0100;
  localparam logic [3:0] OP_BNE = 4'b0101;
  localparam logic [3:0] OP_BLT = 4'b0110;
  localparam logic [3:0] OP_BGE = 4'b0111;
  localparam logic [3:0] OP_BGT = 4'b1000;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_JAL = 4'b1101;

  // Flush down-counter is at least one bit wide so a FLUSH_DEPTH=0 build
  // still elaborates; the FLUSH state is unreachable in that build.
  localparam int              FC_W    = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESOLVE,
    S_FLUSH
  } state_t;

  state_t            state_q, state_d;
  logic              z_reg, s_reg;
  logic              jal_q;
  logic [FC_W-1:0]   flush_cnt;

  logic              accept;
  logic              eff_z, eff_s;
  logic              is_ctrl, is_jump, is_jal, taken;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] off_sext, off_zext;
  logic [ADDR_W-1:0] next_pc;

  assign accept = op.op_valid && op.op_ready;

  // Flags written in the accept cycle are forwarded straight into the
  // condition so a compare-then-branch pair needs no bubble.
  assign eff_z = op.flag_we ? op.alu_zero : z_reg;
  assign eff_s = op.flag_we ? op.alu_sign : s_reg;

  assign pc_plus1 = op.pc + ADDR_W'(1);
  assign off_sext = ADDR_W'($signed(op.offset));
  assign off_zext = ADDR_W'(op.offset);

  // ---------------------------------------------------------------------
  // Opcode decode and target selection.
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    is_ctrl = 1'b0;
    is_jump = 1'b0;
    is_jal  = 1'b0;
    taken   = 1'b0;
    unique case (op.op_code)
      OP_BEQ: begin is_ctrl = 1'b1; taken = eff_z;               end
      OP_BNE: begin is_ctrl = 1'b1; taken = !eff_z;              end
      OP_BLT: begin is_ctrl = 1'b1; taken = eff_s;               end
      OP_BGE: begin is_ctrl = 1'b1; taken = !eff_s;              end
      OP_BGT: begin is_ctrl = 1'b1; taken = !eff_s && !eff_z;    end
      OP_JMP: begin is_ctrl = 1'b1; taken = 1'b1; is_jump = 1'b1; end
      OP_JAL: begin
        is_ctrl = 1'b1;
        taken   = 1'b1;
        is_jump = 1'b1;
        is_jal  = 1'b1;
      end
      default: ;  // non-control: accepted and ignored
    endcase

    if (!taken)       next_pc = pc_plus1;
    else if (is_jump) next_pc = off_zext;
    else              next_pc = op.pc + off_sext;
  end

  // ---------------------------------------------------------------------
  // FSM: state register / next-state / outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (accept && is_ctrl) state_d = S_RESOLVE;
      // jump_branch_flag already holds this op's result in RESOLVE.
      S_RESOLVE: state_d = (jump_branch_flag && (FLUSH_DEPTH > 0)) ? S_FLUSH : S_IDLE;
      S_FLUSH:   if (flush_cnt <= FC_W'(1)) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op.op_ready = (state_q == S_IDLE);
    redirect    = (state_q == S_RESOLVE) && jump_branch_flag;
    link_we     = (state_q == S_RESOLVE) && jump_branch_flag && jal_q;
    flush       = (state_q == S_FLUSH);
  end

  // ---------------------------------------------------------------------
  // Flag register: loads whenever flag_we is high, in any state.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_reg <= 1'b0;
      s_reg <= 1'b0;
    end else if (op.flag_we) begin
      z_reg <= op.alu_zero;
      s_reg <= op.alu_sign;
    end
  end

  // ---------------------------------------------------------------------
  // Result registers: captured on the edge entering RESOLVE and held until
  // the next control op is accepted.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_branch_flag <= 1'b0;
      target_pc        <= '0;
      link_data        <= '0;
      jal_q            <= 1'b0;
    end else if (accept && is_ctrl) begin
      jump_branch_flag <= taken;
      target_pc        <= next_pc;
      jal_q            <= is_jal;
      if (is_jal) link_data <= pc_plus1;
    end
  end

  // Flush down-counter: loaded on the RESOLVE->FLUSH transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       flush_cnt <= '0;
    else if (state_q == S_RESOLVE && state_d == S_FLUSH) flush_cnt <= FC_LOAD;
    else if (state_q == S_FLUSH)                      flush_cnt <= flush_cnt - FC_W'(1);
  end

  // ---------------------------------------------------------------------
  // Performance counters. Both count on the accept edge, where the taken
  // decision is made, so they move together with the result registers.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (cnt_clr) begin
      br_cnt    <= '0;
      taken_cnt <= '0;
    end else if (accept && is_ctrl) begin
      if (br_cnt != '1)             br_cnt    <= br_cnt + CNT_W'(1);
      if (taken && taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule
